// File: rtl/osc_clk_monitor.sv
// Oscillator frequency monitor: counts MON_CLK rising edges per CLK window
// and tracks lock / sticky failure across consecutive window verdicts.
`timescale 1ns/1ps
module osc_clk_monitor #(
    parameter int WINDOW_CYCLES = 5000,
    parameter int MIN_EDGES     = 95,
    parameter int MAX_EDGES     = 105,
    parameter int CNT_W         = 16,
    parameter int LOCK_WINDOWS  = 4
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             EN,
    input  logic             MON_CLK,
    input  logic             FAIL_CLR,
    output logic [CNT_W-1:0] EDGE_COUNT,
    output logic             COUNT_VALID,
    output logic             FREQ_OK,
    output logic             CLK_FAIL,
    output logic [1:0]       STATE
);
    localparam int WIN_W  = $clog2(WINDOW_CYCLES);
    localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WINDOWS - 1);
    localparam logic [CNT_W-1:0]  CNT_LO    = CNT_W'(MIN_EDGES);
    localparam logic [CNT_W-1:0]  CNT_HI    = CNT_W'(MAX_EDGES);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;
    localparam logic [1:0] FAILED  = 2'd3;

    logic              sync1_q, sync2_q, sync3_q;
    logic [1:0]        state_q, state_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  edge_q, edge_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              valid_q, valid_d;
    logic              ok_q, ok_d;
    logic              fail_q, fail_d;

    logic             edge_det;
    logic             term;
    logic             good;
    logic [CNT_W-1:0] edge_sum;

    assign edge_det = sync2_q & ~sync3_q;
    assign term     = (state_q != IDLE) && (win_q == WIN_LAST);
    // Saturating sum includes an edge landing on the terminal cycle
    assign edge_sum = (edge_det && (edge_q != '1)) ? edge_q + 1'b1 : edge_q;
    assign good     = (edge_sum >= CNT_LO) && (edge_sum <= CNT_HI);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        edge_d  = edge_q;
        good_d  = good_q;
        count_d = count_q;
        valid_d = 1'b0;
        fail_d  = FAIL_CLR ? 1'b0 : fail_q;
        if (!EN) begin
            state_d = IDLE;
            win_d   = '0;
            edge_d  = '0;
            good_d  = '0;
        end else begin
            if (state_q != IDLE) begin
                if (term) begin
                    win_d   = '0;
                    edge_d  = '0;
                    count_d = edge_sum;
                    valid_d = 1'b1;
                end else begin
                    win_d  = win_q + 1'b1;
                    edge_d = edge_sum;
                end
            end
            // A FAIL_CLR on the verdict cycle discards that verdict
            unique case (state_q)
                IDLE: state_d = MEASURE;
                MEASURE: begin
                    if (term && !FAIL_CLR) begin
                        if (!good) begin
                            good_d = '0;
                        end else if (good_q == GOOD_LAST) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (term && !FAIL_CLR && !good) begin
                        state_d = FAILED;
                        fail_d  = 1'b1;
                    end
                end
                FAILED: begin
                    if (FAIL_CLR) begin
                        state_d = MEASURE;
                        win_d   = '0;
                        edge_d  = '0;
                        good_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        ok_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            state_q <= IDLE;
            win_q   <= '0;
            edge_q  <= '0;
            good_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            sync1_q <= MON_CLK;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            state_q <= state_d;
            win_q   <= win_d;
            edge_q  <= edge_d;
            good_q  <= good_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
        end
    end

    assign EDGE_COUNT  = count_q;
    assign COUNT_VALID = valid_q;
    assign FREQ_OK     = ok_q;
    assign CLK_FAIL    = fail_q;
    assign STATE       = state_q;

endmodule

// File: tb/tb_osc_clk_monitor.sv
// Directed bench for osc_clk_monitor using a short 400-cycle window
// so that ~100 MON_CLK pulses per window mirror the nominal 95..105 band.
`timescale 1ns/1ps
module tb_osc_clk_monitor;
    localparam int WIN = 400;

    localparam int A_NONE = 0;
    localparam int A_REEN = 1;
    localparam int A_CLR  = 2;
    localparam int A_CLRV = 3;
    localparam int A_CLRM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        mon = 1'b0;
    logic        fclr = 1'b0;
    logic [15:0] edge_count;
    logic        count_valid;
    logic        freq_ok;
    logic        clk_fail;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    osc_clk_monitor #(
        .WINDOW_CYCLES(WIN),
        .MIN_EDGES(95),
        .MAX_EDGES(105),
        .CNT_W(16),
        .LOCK_WINDOWS(4)
    ) dut (
        .CLK(clk),
        .RESETN(rst_n),
        .EN(en),
        .MON_CLK(mon),
        .FAIL_CLR(fclr),
        .EDGE_COUNT(edge_count),
        .COUNT_VALID(count_valid),
        .FREQ_OK(freq_ok),
        .CLK_FAIL(clk_fail),
        .STATE(state)
    );

    typedef struct {
        int edges;
        int act;
        int st;
        int ok;
        int fl;
    } vec_t;

    vec_t vecs[30];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One full window from its first negedge; pulses sit well inside it
    task automatic run_window(input int edges, input int act,
                              output int extra);
        extra = 0;
        for (int i = 0; i < WIN; i++) begin
            mon = (i >= 10) && ((i - 10) % 3 == 0)
                  && ((i - 10) / 3 < edges);
            if (act == A_CLRV) fclr = (i == WIN - 1);
            if (act == A_CLRM) fclr = (i == 200);
            @(negedge clk);
            if (i < WIN - 1 && count_valid) extra++;
        end
        mon  = 1'b0;
        fclr = 1'b0;
    endtask

    initial begin
        int extra;
        int cv;

        vecs[0]  = '{100, A_NONE, 1, 0, 0};
        vecs[1]  = '{100, A_NONE, 1, 0, 0};
        vecs[2]  = '{100, A_NONE, 1, 0, 0};
        vecs[3]  = '{100, A_NONE, 2, 1, 0};
        vecs[4]  = '{100, A_NONE, 2, 1, 0};
        vecs[5]  = '{0,   A_NONE, 3, 0, 1};
        vecs[6]  = '{100, A_REEN, 1, 0, 1};
        vecs[7]  = '{100, A_NONE, 1, 0, 1};
        vecs[8]  = '{100, A_NONE, 1, 0, 1};
        vecs[9]  = '{120, A_NONE, 1, 0, 1};
        vecs[10] = '{100, A_NONE, 1, 0, 1};
        vecs[11] = '{100, A_NONE, 1, 0, 1};
        vecs[12] = '{100, A_NONE, 1, 0, 1};
        vecs[13] = '{100, A_NONE, 2, 1, 1};
        vecs[14] = '{106, A_NONE, 3, 0, 1};
        vecs[15] = '{100, A_CLR,  1, 0, 0};
        vecs[16] = '{95,  A_NONE, 1, 0, 0};
        vecs[17] = '{105, A_NONE, 1, 0, 0};
        vecs[18] = '{94,  A_NONE, 1, 0, 0};
        vecs[19] = '{95,  A_NONE, 1, 0, 0};
        vecs[20] = '{105, A_NONE, 1, 0, 0};
        vecs[21] = '{100, A_NONE, 1, 0, 0};
        vecs[22] = '{100, A_CLRV, 1, 0, 0};
        vecs[23] = '{100, A_NONE, 2, 1, 0};
        vecs[24] = '{94,  A_CLRV, 2, 1, 0};
        vecs[25] = '{106, A_NONE, 3, 0, 1};
        vecs[26] = '{100, A_REEN, 1, 0, 1};
        vecs[27] = '{100, A_CLRM, 1, 0, 0};
        vecs[28] = '{100, A_NONE, 1, 0, 0};
        vecs[29] = '{100, A_NONE, 2, 1, 0};

        en = 1'b1;
        repeat (6) begin
            @(negedge clk);
            mon = ~mon;
        end
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(edge_count), 0);
        chk("rst_valid", int'(count_valid), 0);
        chk("rst_freq_ok", int'(freq_ok), 0);
        chk("rst_clk_fail", int'(clk_fail), 0);
        mon   = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("start_state", int'(state), 1);

        for (int v = 0; v < 30; v++) begin
            if (vecs[v].act == A_REEN) begin
                en = 1'b0;
                @(negedge clk);
                chk("reen_idle", int'(state), 0);
                chk("reen_fail_held", int'(clk_fail), vecs[v].fl);
                en = 1'b1;
                @(negedge clk);
                chk("reen_measure", int'(state), 1);
            end
            if (vecs[v].act == A_CLR) begin
                fclr = 1'b1;
                @(negedge clk);
                fclr = 1'b0;
                chk("clr_state", int'(state), 1);
                chk("clr_fail", int'(clk_fail), 0);
            end
            run_window(vecs[v].edges, vecs[v].act, extra);
            chk($sformatf("w%0d_valid", v), int'(count_valid), 1);
            chk($sformatf("w%0d_count", v), int'(edge_count),
                vecs[v].edges);
            chk($sformatf("w%0d_state", v), int'(state), vecs[v].st);
            chk($sformatf("w%0d_freq_ok", v), int'(freq_ok), vecs[v].ok);
            chk($sformatf("w%0d_clk_fail", v), int'(clk_fail),
                vecs[v].fl);
            chk($sformatf("w%0d_valid_quiet", v), extra, 0);
        end

        repeat (200) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("abort_state", int'(state), 0);
        chk("abort_freq_ok", int'(freq_ok), 0);
        cv = 0;
        repeat (450) begin
            @(negedge clk);
            if (count_valid) cv++;
        end
        chk("abort_no_valid", cv, 0);
        chk("abort_hold_count", int'(edge_count), 100);
        chk("abort_stay_idle", int'(state), 0);

        en = 1'b1;
        @(negedge clk);
        chk("reen2_state", int'(state), 1);
        repeat (200) begin
            mon = ~mon;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_state", int'(state), 0);
        chk("midrst_count", int'(edge_count), 0);
        chk("midrst_valid", int'(count_valid), 0);
        chk("midrst_freq_ok", int'(freq_ok), 0);
        chk("midrst_clk_fail", int'(clk_fail), 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/osc_clk_monitor.md
OSC_CLK_MONITOR -- requirements
Module: osc_clk_monitor

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: WINDOW_CYCLES, 5000, CLK cycles per measurement window; MIN_EDGES, 95, lowest in-range edge count; MAX_EDGES, 105, highest in-range edge count; CNT_W, 16, edge-count width; LOCK_WINDOWS, 4, consecutive in-range windows required to lock.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- CLK, in, 1, system clock (fabric RC oscillator output, 50 MHz); one clock, all logic on its rising edge.
- RESETN, in, 1, asynchronous active-low reset.
- EN, in, 1, monitor enable.
- MON_CLK, in, 1, monitored oscillator, asynchronous to CLK and treated as data.
- FAIL_CLR, in, 1, one-cycle clear of the sticky failure.
- EDGE_COUNT, out, CNT_W, rising-edge count of the last completed window.
- COUNT_VALID, out, 1, one-cycle pulse when EDGE_COUNT updates.
- FREQ_OK, out, 1, high only in LOCKED.
- CLK_FAIL, out, 1, sticky failure flag.
- STATE, out, 2, FSM state: IDLE=0, MEASURE=1, LOCKED=2, FAILED=3.

Function
REQ-003 MON_CLK SHALL pass through a 2-flop synchronizer and then a third flop; a rising edge is detected when sync2=1 and sync3=0, 3 CLK cycles after the input transition.
REQ-004 The window counter SHALL count 0..WINDOW_CYCLES-1 while STATE is MEASURE, LOCKED or FAILED, then wrap to 0.
REQ-005 The edge counter SHALL increment per detected edge, saturate at 2^CNT_W-1, and reload to 0 at the window's terminal cycle.
REQ-006 An edge in the terminal cycle SHALL count toward the closing window.
REQ-007 At the terminal cycle the final count SHALL be registered into EDGE_COUNT, and COUNT_VALID SHALL pulse high for exactly the next cycle.
REQ-008 A window SHALL be "good" iff MIN_EDGES <= count <= MAX_EDGES, inclusive at both bounds.
REQ-009 FSM transitions:
- IDLE -> MEASURE when EN=1, with counters and good-count starting at 0.
- MEASURE: a good window increments the good-count; a bad window clears it to 0; reaching LOCK_WINDOWS -> LOCKED.
- LOCKED: any bad window -> FAILED and CLK_FAIL=1.
- FAILED: remains until FAIL_CLR=1 -> MEASURE, with good-count 0 and the window restarted.
REQ-010 EN=0 in any state SHALL move the FSM to IDLE on the next cycle, clear the window/edge/good counters, suppress COUNT_VALID, and hold EDGE_COUNT and CLK_FAIL.
REQ-011 FREQ_OK SHALL be registered and equal (STATE==LOCKED); it falls in the same cycle the FSM enters FAILED.
REQ-012 CLK_FAIL SHALL set on entry to FAILED and clear only on FAIL_CLR or reset.
REQ-013 FAIL_CLR in a state other than FAILED SHALL clear CLK_FAIL without changing state.
REQ-014 FAIL_CLR coincident with a window verdict SHALL win: the verdict for that window is discarded.
REQ-015 WINDOW_CYCLES >= 2 and MIN_EDGES <= MAX_EDGES < 2^CNT_W SHALL be required; the counter width is derived with $clog2.

Reset
REQ-016 RESETN low SHALL immediately force: STATE=IDLE, EDGE_COUNT=0, COUNT_VALID=0, FREQ_OK=0, CLK_FAIL=0, all counters and synchronizer flops=0.
REQ-017 Reset deassertion SHALL take effect on the first CLK edge after release; reset mid-window abandons that window with no COUNT_VALID.

Verification
REQ-018 Reset check: RESETN low, EN=1, MON_CLK toggling -> all outputs 0, STATE=0; after release with EN=1 -> STATE=1 on the next edge.
REQ-019 Nominal lock: MON_CLK=1 MHz, CLK=50 MHz, EN=1 -> COUNT_VALID every 5000 cycles, EDGE_COUNT in 99..101, FREQ_OK=1 right after the 4th window verdict.
REQ-020 Failure: from LOCKED, hold MON_CLK low -> next verdict EDGE_COUNT=0, STATE=3, FREQ_OK=0, CLK_FAIL=1; CLK_FAIL still 1 after EN toggles 0->1.
REQ-021 Good-count reset and bounds:
- Apply 3 windows at 1 MHz, then 1 window at 1.2 MHz (120 edges), then 4 windows at 1 MHz -> lock only after the final 4.
- Exactly 95 and exactly 105 edges -> good; 94 and 106 -> bad.
REQ-022 Clear and restart:
- FAIL_CLR pulse in FAILED with 1 MHz restored -> CLK_FAIL=0 next cycle, STATE=1, relock after 4 windows.
- FAIL_CLR on the verdict cycle -> that verdict is ignored.
REQ-023 Mid-operation abort:
- EN=0 at window cycle 2500 -> STATE=0 next cycle, no COUNT_VALID, EDGE_COUNT unchanged.
- RESETN pulse at cycle 2500 -> all outputs 0 immediately.
